key_scan_in: RTL and testbench
==============================

Name: key_scan_in

Overview:
- Input-side counterpart to the LED output driver: samples 8 raw push-buttons, synchronizes and debounces them, and latches press events.
- Exposes debounced key state, a sticky pending register with per-bit clear, a lowest-index key code and a maskable interrupt.
- Sits on the same bus-register interface as the LED driver; software reads keys to select LED mode and speed.

Parameters:
- STABLE_TICKS, 4: number of consecutive sample ticks a synchronized key must differ from its debounced state before the state changes (range 1..255).
- KEY_ACTIVE_LOW, 1: 1 means a raw key is pressed when 0; 0 means pressed when 1.

Ports:
- clk  input  1  system clock
- RST  input  1  synchronous reset, active-high
- KEY_raw  input  8  asynchronous raw button pins
- Key_sample_div  input  32  sample tick period minus one, in clk cycles
- Key_irq_en  input  8  per-key interrupt enable mask
- Key_clear  input  8  write-1-to-clear pulse for pending bits, one cycle
- Key_state  output  8  debounced key state, 1 = pressed
- Key_pending  output  8  sticky press-event flags
- Key_code  output  3  index of lowest set pending bit
- Key_valid  output  1  OR of Key_pending
- Key_irq  output  1  OR of (Key_pending AND Key_irq_en)

Behaviour:
- All state updates occur on posedge clk. When RST=1 at an edge:
  - sync stages load the inactive level (8'hFF if KEY_ACTIVE_LOW, else 8'h00).
  - div_cnt, all stable counters, Key_state and Key_pending clear to 0.
  - Outputs after reset: Key_state=0, Key_pending=0, Key_code=0, Key_valid=0, Key_irq=0.
  - RST asserted mid-debounce abandons all in-progress counts.
- Synchronizer: two-flop chain per bit. Pressed level is key_s = sync2 XOR {8{KEY_ACTIVE_LOW}}, giving 1 = pressed.
- Tick generator:
  - 32-bit div_cnt. When div_cnt == Key_sample_div, tick=1 for that cycle and div_cnt resets to 0; otherwise div_cnt increments.
  - Key_sample_div=0 gives a tick every cycle.
  - If Key_sample_div changes below the current div_cnt, div_cnt runs up to 2^32-1 and wraps to 0. No special handling is required; this must be documented in the driver.
- Debounce, per key i, evaluated only on tick cycles:
  - If key_s[i] == Key_state[i], cnt[i] <= 0.
  - Else, if cnt[i] == STABLE_TICKS-1: Key_state[i] <= key_s[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - A single disagreeing tick followed by an agreeing tick restarts the count from 0. Glitches shorter than STABLE_TICKS ticks never reach Key_state.
- Latency:
  - Raw edge to key_s is 2 clk cycles.
  - Key_state changes on the STABLE_TICKS-th tick that sees the new level.
  - With Key_sample_div=0 and STABLE_TICKS=4, raw edge to Key_state is 6 cycles.
- Press events:
  - When Key_state[i] goes 0->1, Key_pending[i] is set on the same edge as the state update.
  - Releases (1->0) do not set pending.
  - Key_pending[i] is cleared on an edge where Key_clear[i]=1.
  - If set and clear coincide on the same bit, set wins and the bit stays 1.
  - Clear of an already-0 bit has no effect.
  - Pending bits stay set while the key is held and across later releases.
- Key_code, Key_valid and Key_irq are combinational from the registered Key_pending:
  - Key_code is the priority encode of the lowest set bit, or 0 when none is set.
  - Key_irq is a level, not a pulse. It deasserts in the cycle after all enabled pending bits are cleared.
- Multiple keys pressed simultaneously: each bit debounces independently, all set pending on the same edge, and Key_code reports the lowest index.

Test Plan:
- Reset:
  - Stimulus: STABLE_TICKS=4, KEY_ACTIVE_LOW=1, KEY_raw=8'hFF, RST=1 for 3 cycles then release.
  - Required: Key_state=0, Key_pending=0, Key_valid=0, Key_irq=0 throughout; no events for 100 cycles.
- Clean press:
  - Stimulus: Key_sample_div=0, KEY_raw[2] driven 0 at cycle T.
  - Required: Key_state=8'h04 and Key_pending=8'h04 from edge T+6; Key_code=2, Key_valid=1; Key_irq=1 only if Key_irq_en[2]=1.
- Glitch rejection:
  - Stimulus: Key_sample_div=9, KEY_raw[0] low for 25 cycles (at most 3 ticks), then high.
  - Required: Key_state and Key_pending remain 0.
  - Repeat with the key held low for 50 cycles: Key_state[0]=1 after the 4th tick, i.e. within 40 cycles plus 2 of the edge.
- Clear semantics:
  - Stimulus: pending=8'h12, pulse Key_clear=8'h02.
  - Required: pending=8'h10 and Key_code=4 next cycle.
  - Pulse Key_clear[4] on the same edge as a new key-4 press: pending[4] stays 1.
- Release and multi-key:
  - Stimulus: keys 7 and 5 pressed together, then released.
  - Required: pending=8'hA0 and Key_code=5 after press; release clears Key_state to 0 but leaves pending at 8'hA0.
  - With Key_irq_en=8'h80, clearing bit 7 drops Key_irq while Key_valid stays 1.
- Reset mid-debounce:
  - Stimulus: assert RST after 2 of 4 ticks of a press, deassert, and keep the key held.
  - Required: a full 2 sync cycles plus 4 ticks are needed again before Key_state sets.

Source files
------------

// File: rtl/key_scan_in.sv
// Eight-key scanner: two-flop synchronizer, tick-paced per-key debounce,
// sticky press-event flags with write-1-to-clear, lowest-index code and maskable IRQ.
module key_scan_in #(
   parameter int unsigned STABLE_TICKS   = 4,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [7:0]  KEY_raw,
   input  logic [31:0] Key_sample_div,
   input  logic [7:0]  Key_irq_en,
   input  logic [7:0]  Key_clear,
   output logic [7:0]  Key_state,
   output logic [7:0]  Key_pending,
   output logic [2:0]  Key_code,
   output logic        Key_valid,
   output logic        Key_irq
);

   localparam logic [7:0] INACTIVE = KEY_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [7:0] CNT_LAST = 8'(STABLE_TICKS - 1);

   logic [7:0]  sync1_q, sync2_q;
   logic [31:0] div_cnt_q, div_cnt_d;
   logic [7:0]  cnt_q [8];
   logic [7:0]  cnt_d [8];
   logic [7:0]  state_q, state_d;
   logic [7:0]  pending_q, pending_d;
   logic [7:0]  key_s;
   logic        tick;

   assign key_s = sync2_q ^ {8{KEY_ACTIVE_LOW}};
   // A divisor lowered below the running count lets div_cnt wrap through 2^32.
   assign tick  = (div_cnt_q == Key_sample_div);

   always_comb begin
      div_cnt_d = tick ? 32'd0 : div_cnt_q + 32'd1;
   end

   always_comb begin
      state_d = state_q;
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (key_s[i] == state_q[i]) begin
               cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == CNT_LAST) begin
               state_d[i] = key_s[i];
               cnt_d[i]   = 8'd0;
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
   end

   // Set wins over a coincident clear on the same bit.
   always_comb begin
      pending_d = (pending_q & ~Key_clear) | (state_d & ~state_q);
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         sync1_q   <= INACTIVE;
         sync2_q   <= INACTIVE;
         div_cnt_q <= 32'd0;
         state_q   <= 8'd0;
         pending_q <= 8'd0;
         for (int i = 0; i < 8; i++) cnt_q[i] <= 8'd0;
      end else begin
         sync1_q   <= KEY_raw;
         sync2_q   <= sync1_q;
         div_cnt_q <= div_cnt_d;
         state_q   <= state_d;
         pending_q <= pending_d;
         for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      Key_code = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pending_q[i]) Key_code = 3'(i);
      end
   end

   assign Key_state   = state_q;
   assign Key_pending = pending_q;
   assign Key_valid   = |pending_q;
   assign Key_irq     = |(pending_q & Key_irq_en);

endmodule

// File: tb/tb_key_scan_in.sv
// Directed bench for key_scan_in with STABLE_TICKS=4, active-low keys.
module tb_key_scan_in;

   logic        clk = 1'b0;
   logic        RST;
   logic [7:0]  KEY_raw;
   logic [31:0] Key_sample_div;
   logic [7:0]  Key_irq_en;
   logic [7:0]  Key_clear;
   logic [7:0]  Key_state;
   logic [7:0]  Key_pending;
   logic [2:0]  Key_code;
   logic        Key_valid;
   logic        Key_irq;

   int checks = 0;
   int errors = 0;

   key_scan_in #(.STABLE_TICKS(4), .KEY_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .RST(RST), .KEY_raw(KEY_raw), .Key_sample_div(Key_sample_div),
      .Key_irq_en(Key_irq_en), .Key_clear(Key_clear), .Key_state(Key_state),
      .Key_pending(Key_pending), .Key_code(Key_code), .Key_valid(Key_valid),
      .Key_irq(Key_irq)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear(input logic [7:0] m);
      Key_clear = m;
      cyc(1);
      Key_clear = 8'h00;
   endtask

   task automatic test_reset;
      int bad;
      RST = 1'b1; KEY_raw = 8'hFF; Key_sample_div = 32'd0;
      Key_irq_en = 8'hFF; Key_clear = 8'h00;
      cyc(3);
      RST = 1'b0;
      checks++; if (Key_state !== 8'h00) begin errors++; $display("FAIL reset_state got %h exp 00", Key_state); end
      checks++; if (Key_pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h exp 00", Key_pending); end
      checks++; if (Key_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", Key_code); end
      checks++; if (Key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", Key_valid); end
      checks++; if (Key_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", Key_irq); end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         if (Key_state !== 8'h00 || Key_pending !== 8'h00 || Key_valid !== 1'b0 || Key_irq !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL idle_events got %0d cycles exp 0", bad); end
   endtask

   task automatic test_clean_press;
      Key_irq_en = 8'h04;
      KEY_raw = 8'hFB;
      cyc(5);
      checks++; if (Key_state !== 8'h00) begin errors++; $display("FAIL press_early got %h exp 00", Key_state); end
      cyc(1);
      checks++; if (Key_state !== 8'h04) begin errors++; $display("FAIL press_state got %h exp 04", Key_state); end
      checks++; if (Key_pending !== 8'h04) begin errors++; $display("FAIL press_pending got %h exp 04", Key_pending); end
      checks++; if (Key_code !== 3'd2) begin errors++; $display("FAIL press_code got %0d exp 2", Key_code); end
      checks++; if (Key_valid !== 1'b1) begin errors++; $display("FAIL press_valid got %b exp 1", Key_valid); end
      checks++; if (Key_irq !== 1'b1) begin errors++; $display("FAIL press_irq got %b exp 1", Key_irq); end
      Key_irq_en = 8'hFB;
      #1;
      checks++; if (Key_irq !== 1'b0) begin errors++; $display("FAIL press_irq_masked got %b exp 0", Key_irq); end
      KEY_raw = 8'hFF;
      cyc(6);
      checks++; if (Key_state !== 8'h00) begin errors++; $display("FAIL release_state got %h exp 00", Key_state); end
      checks++; if (Key_pending !== 8'h04) begin errors++; $display("FAIL release_pending got %h exp 04", Key_pending); end
      pulse_clear(8'h04);
      checks++; if (Key_pending !== 8'h00) begin errors++; $display("FAIL press_clear got %h exp 00", Key_pending); end
   endtask

   task automatic test_glitch;
      int n;
      Key_sample_div = 32'd9;
      KEY_raw = 8'hFE;
      cyc(25);
      KEY_raw = 8'hFF;
      cyc(40);
      checks++; if (Key_state !== 8'h00) begin errors++; $display("FAIL glitch_state got %h exp 00", Key_state); end
      checks++; if (Key_pending !== 8'h00) begin errors++; $display("FAIL glitch_pending got %h exp 00", Key_pending); end
      KEY_raw = 8'hFE;
      n = 0;
      while (Key_state[0] !== 1'b1 && n < 50) begin
         cyc(1);
         n++;
      end
      checks++; if (n < 33 || n > 42) begin errors++; $display("FAIL slow_press_latency got %0d cycles exp 33..42", n); end
      checks++; if (Key_pending !== 8'h01) begin errors++; $display("FAIL slow_press_pending got %h exp 01", Key_pending); end
      // Reset restores div_cnt to 0 so dropping the divisor cannot cause a wrap.
      KEY_raw = 8'hFF; Key_sample_div = 32'd0; RST = 1'b1;
      cyc(1);
      RST = 1'b0;
      cyc(3);
      checks++; if (Key_pending !== 8'h00) begin errors++; $display("FAIL glitch_reset_pending got %h exp 00", Key_pending); end
   endtask

   task automatic test_clear;
      KEY_raw = 8'hED;
      cyc(6);
      checks++; if (Key_pending !== 8'h12) begin errors++; $display("FAIL clr_setup_pending got %h exp 12", Key_pending); end
      checks++; if (Key_code !== 3'd1) begin errors++; $display("FAIL clr_setup_code got %0d exp 1", Key_code); end
      KEY_raw = 8'hFF;
      cyc(6);
      pulse_clear(8'h02);
      checks++; if (Key_pending !== 8'h10) begin errors++; $display("FAIL clr_bit1_pending got %h exp 10", Key_pending); end
      checks++; if (Key_code !== 3'd4) begin errors++; $display("FAIL clr_bit1_code got %0d exp 4", Key_code); end
      pulse_clear(8'h10);
      checks++; if (Key_pending !== 8'h00) begin errors++; $display("FAIL clr_bit4_pending got %h exp 00", Key_pending); end
      KEY_raw = 8'hEF;
      cyc(5);
      pulse_clear(8'h10);
      checks++; if (Key_state !== 8'h10) begin errors++; $display("FAIL setwins_state got %h exp 10", Key_state); end
      checks++; if (Key_pending !== 8'h10) begin errors++; $display("FAIL setwins_pending got %h exp 10", Key_pending); end
      pulse_clear(8'h01);
      checks++; if (Key_pending !== 8'h10) begin errors++; $display("FAIL clr_zero_bit got %h exp 10", Key_pending); end
      KEY_raw = 8'hFF;
      cyc(6);
      pulse_clear(8'h10);
      checks++; if (Key_pending !== 8'h00) begin errors++; $display("FAIL clr_final got %h exp 00", Key_pending); end
   endtask

   task automatic test_multi;
      Key_irq_en = 8'h80;
      KEY_raw = 8'h5F;
      cyc(6);
      checks++; if (Key_state !== 8'hA0) begin errors++; $display("FAIL multi_state got %h exp a0", Key_state); end
      checks++; if (Key_pending !== 8'hA0) begin errors++; $display("FAIL multi_pending got %h exp a0", Key_pending); end
      checks++; if (Key_code !== 3'd5) begin errors++; $display("FAIL multi_code got %0d exp 5", Key_code); end
      checks++; if (Key_irq !== 1'b1) begin errors++; $display("FAIL multi_irq got %b exp 1", Key_irq); end
      KEY_raw = 8'hFF;
      cyc(6);
      checks++; if (Key_state !== 8'h00) begin errors++; $display("FAIL multi_rel_state got %h exp 00", Key_state); end
      checks++; if (Key_pending !== 8'hA0) begin errors++; $display("FAIL multi_rel_pending got %h exp a0", Key_pending); end
      pulse_clear(8'h80);
      checks++; if (Key_irq !== 1'b0) begin errors++; $display("FAIL multi_irq_drop got %b exp 0", Key_irq); end
      checks++; if (Key_valid !== 1'b1) begin errors++; $display("FAIL multi_valid_hold got %b exp 1", Key_valid); end
      checks++; if (Key_code !== 3'd5) begin errors++; $display("FAIL multi_code_after got %0d exp 5", Key_code); end
      pulse_clear(8'h20);
      checks++; if (Key_valid !== 1'b0) begin errors++; $display("FAIL multi_valid_drop got %b exp 0", Key_valid); end
   endtask

   task automatic test_reset_mid;
      KEY_raw = 8'hF7;
      cyc(4);
      RST = 1'b1;
      cyc(1);
      RST = 1'b0;
      cyc(5);
      checks++; if (Key_state !== 8'h00) begin errors++; $display("FAIL rstmid_early got %h exp 00", Key_state); end
      cyc(1);
      checks++; if (Key_state !== 8'h08) begin errors++; $display("FAIL rstmid_state got %h exp 08", Key_state); end
      checks++; if (Key_pending !== 8'h08) begin errors++; $display("FAIL rstmid_pending got %h exp 08", Key_pending); end
      checks++; if (Key_code !== 3'd3) begin errors++; $display("FAIL rstmid_code got %0d exp 3", Key_code); end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_clear();
      test_multi();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
